// File: rtl/test_status_display.sv
// Status display for an SDRAM test run: tracks run state, error and pass counts,
// and presents one of three pages on a 4-bit hex output with optional auto-scroll.
module test_status_display #(
   parameter int PASS_DIV      = 1024,
   parameter int SCROLL_CYCLES = 50_000_000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_pass,
   input  logic       i_fail,
   input  logic       i_done,
   input  logic       i_key,
   output logic [3:0] o_hex,
   output logic [1:0] o_page,
   output logic       o_busy
);

   localparam int PW = (PASS_DIV > 2) ? $clog2(PASS_DIV) : 1;
   localparam int SW = (SCROLL_CYCLES > 2) ? $clog2(SCROLL_CYCLES) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PASS_DIV - 1);
   localparam logic [SW-1:0] SCR_LAST = SW'(SCROLL_CYCLES - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t        state, state_nxt;
   logic [3:0]    err_cnt, pass_cnt;
   logic [PW-1:0] prescaler;
   logic [SW-1:0] scroll_tmr;
   logic [1:0]    page;
   logic          run, clear, scroll_tc, adv_page;
   logic [3:0]    hex_nxt;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   function automatic logic [1:0] next_page(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   always_comb begin
      run       = (state == RUN);
      clear     = i_start && !run;
      state_nxt = state;
      case (state)
         IDLE:    if (i_start) state_nxt = RUN;
         RUN:     if (i_done)  state_nxt = DONE;
         DONE:    if (i_start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
      scroll_tc = (state == DONE) && (scroll_tmr == SCR_LAST);
      adv_page  = i_key || scroll_tc;
      hex_nxt   = 4'h0;
      case (page)
         2'd0: begin
            case (state)
               RUN:     hex_nxt = 4'h1;
               DONE:    hex_nxt = (err_cnt == 4'h0) ? 4'hA : 4'hE;
               default: hex_nxt = 4'h0;
            endcase
         end
         2'd1:    hex_nxt = err_cnt;
         2'd2:    hex_nxt = pass_cnt;
         default: hex_nxt = 4'h0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         err_cnt    <= 4'h0;
         pass_cnt   <= 4'h0;
         prescaler  <= '0;
         scroll_tmr <= '0;
         page       <= 2'd0;
         o_hex      <= 4'h0;
         o_page     <= 2'd0;
         o_busy     <= 1'b0;
      end else begin
         state  <= state_nxt;
         o_busy <= (state_nxt == RUN);
         // Counting stays live in the cycle i_done arrives; start only clears outside RUN.
         if (clear) begin
            err_cnt   <= 4'h0;
            pass_cnt  <= 4'h0;
            prescaler <= '0;
         end else if (run) begin
            if (i_fail) err_cnt <= sat_inc4(err_cnt);
            if (i_pass) begin
               if (prescaler == PRE_LAST) begin
                  prescaler <= '0;
                  pass_cnt  <= sat_inc4(pass_cnt);
               end else begin
                  prescaler <= prescaler + 1'b1;
               end
            end
         end
         if (adv_page) page <= next_page(page);
         if ((state != DONE) || adv_page) scroll_tmr <= '0;
         else                              scroll_tmr <= scroll_tmr + 1'b1;
         o_hex  <= hex_nxt;
         o_page <= page;
      end
   end

endmodule

// File: tb/tb_test_status_display.sv
// Directed bench for test_status_display with a cycle model feeding an expectation queue.
module tb_test_status_display;

   localparam int PD = 4;
   localparam int SC = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0, pass = 1'b0, fail = 1'b0, done = 1'b0, key = 1'b0;
   logic [3:0] o_hex;
   logic [1:0] o_page;
   logic       o_busy;

   int n_cmp = 0;
   int n_mis = 0;
   logic [6:0] sb[$];

   int m_state, m_err, m_pass, m_presc, m_tmr;
   logic [1:0] m_page;

   test_status_display #(.PASS_DIV(PD), .SCROLL_CYCLES(SC)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pass(pass), .i_fail(fail),
      .i_done(done), .i_key(key), .o_hex(o_hex), .o_page(o_page), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   task automatic compare(input string tag, input logic [6:0] got, input logic [6:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_mis++;
         $error("FAIL %s: observed hex/page/busy=%h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_err = 0; m_pass = 0; m_presc = 0; m_tmr = 0; m_page = 2'd0;
   endtask

   function automatic logic [3:0] model_hex();
      if (m_page == 2'd1) return 4'(m_err);
      if (m_page == 2'd2) return 4'(m_pass);
      if (m_state == 1) return 4'h1;
      if (m_state == 2) return (m_err == 0) ? 4'hA : 4'hE;
      return 4'h0;
   endfunction

   // One clock: drive inputs, queue the model's expected outputs, compare after the edge.
   task automatic tick(input string tag, input bit s, input bit p, input bit f,
                       input bit d, input bit k);
      int  nst;
      bit  tc;
      logic [6:0] exp;
      start = s; pass = p; fail = f; done = d; key = k;
      nst = m_state;
      if (m_state != 1 && s) nst = 1;
      if (m_state == 1 && d) nst = 2;
      exp = {model_hex(), m_page, logic'(nst == 1)};
      if (m_state != 1 && s) begin
         m_err = 0; m_pass = 0; m_presc = 0;
      end else if (m_state == 1) begin
         if (f && m_err < 15) m_err++;
         if (p) begin
            m_presc++;
            if (m_presc == PD) begin
               m_presc = 0;
               if (m_pass < 15) m_pass++;
            end
         end
      end
      tc = (m_state == 2) && (m_tmr == SC - 1);
      if (k || tc) m_page = (m_page == 2'd2) ? 2'd0 : m_page + 2'd1;
      m_tmr = (m_state != 2 || k || tc) ? 0 : m_tmr + 1;
      m_state = nst;
      sb.push_back(exp);
      @(posedge clk);
      #1;
      if (sb.size() == 0) compare({tag, " underflow"}, 7'h7F, 7'h00);
      else compare(tag, {o_hex, o_page, o_busy}, sb.pop_front());
      start = 0; pass = 0; fail = 0; done = 0; key = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick("idle", 0, 0, 0, 0, 0);
   endtask

   task automatic goto_page(input logic [1:0] p);
      for (int i = 0; i < 3 && m_page != p; i++) tick("key", 0, 0, 0, 0, 1);
      idle(1);
   endtask

   initial begin
      model_reset();
      #1 rst_n = 0;
      #3 compare("reset_out", {o_hex, o_page, o_busy}, 7'h00);
      #8 rst_n = 1;

      // Basic run with three errors, then page 1
      tick("start", 1, 0, 0, 0, 0);
      tick("run0", 0, 0, 0, 0, 0);
      compare("page0_run", {o_hex, o_page, o_busy}, {4'h1, 2'd0, 1'b1});
      for (int i = 0; i < 3; i++) tick("fail", 0, 0, 1, 0, 0);
      tick("done", 0, 0, 0, 1, 0);
      idle(1);
      compare("page0_done_err", {o_hex, o_page, o_busy}, {4'hE, 2'd0, 1'b0});
      tick("key", 0, 0, 0, 0, 1);
      idle(1);
      compare("page1_err3", {o_hex, o_page, o_busy}, {4'h3, 2'd1, 1'b0});

      // Pass prescaling and saturation
      goto_page(2'd2);
      tick("start", 1, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) tick("pass", 0, 1, 0, 0, 0);
      tick("done", 0, 0, 0, 1, 0);
      idle(1);
      compare("pass9", {o_hex, o_page, o_busy}, {4'h2, 2'd2, 1'b0});
      tick("start", 1, 0, 0, 0, 0);
      for (int i = 0; i < 70; i++) tick("pass", 0, 1, 0, 0, 0);
      tick("done", 0, 0, 0, 1, 0);
      idle(1);
      compare("pass70_sat", {o_hex, o_page, o_busy}, {4'hF, 2'd2, 1'b0});

      // Error saturation with simultaneous pass/fail
      tick("start", 1, 0, 0, 0, 0);
      for (int i = 0; i < 15; i++) tick("fail", 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) tick("pass_fail", 0, 1, 1, 0, 0);
      tick("done", 0, 0, 0, 1, 0);
      goto_page(2'd1);
      compare("err_sat", {o_hex, o_page, o_busy}, {4'hF, 2'd1, 1'b0});
      goto_page(2'd2);
      compare("pass_after_5", {o_hex, o_page, o_busy}, {4'h1, 2'd2, 1'b0});

      // Auto-scroll in DONE, static page in RUN, key at terminal count
      tick("start", 1, 0, 0, 0, 0);
      idle(6);
      tick("done", 0, 0, 0, 1, 0);
      idle(30);
      for (int i = 0; i < SC && m_tmr != SC - 1; i++) tick("wait_tc", 0, 0, 0, 0, 0);
      tick("key_at_tc", 0, 0, 0, 0, 1);
      idle(10);

      // Start ignored in RUN, start+done together, then reset mid-run
      tick("start", 1, 0, 0, 0, 0);
      tick("fail", 0, 0, 1, 0, 0);
      tick("fail", 0, 0, 1, 0, 0);
      tick("start_in_run", 1, 0, 0, 0, 0);
      tick("start_done", 1, 0, 0, 1, 0);
      goto_page(2'd1);
      compare("start_done_kept", {o_hex, o_page, o_busy}, {4'h2, 2'd1, 1'b0});
      tick("start", 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) tick("fail", 0, 0, 1, 0, 0);
      idle(1);
      compare("pre_reset", {o_hex, o_page, o_busy}, {4'h4, 2'd1, 1'b1});
      rst_n = 0;
      #2 compare("async_reset", {o_hex, o_page, o_busy}, 7'h00);
      model_reset();
      #2 rst_n = 1;

      // Ignored inputs in IDLE and DONE
      tick("idle_pass", 0, 1, 0, 0, 0);
      tick("idle_fail", 0, 0, 1, 0, 0);
      tick("idle_done", 0, 0, 0, 1, 0);
      tick("idle_pf", 0, 1, 1, 0, 0);
      compare("idle_ignored", {o_hex, o_page, o_busy}, 7'h00);
      tick("start", 1, 0, 0, 0, 0);
      tick("fail", 0, 0, 1, 0, 0);
      tick("done", 0, 0, 0, 1, 0);
      tick("done_pass", 0, 1, 0, 0, 0);
      tick("done_fail", 0, 0, 1, 0, 0);
      tick("done_pf", 0, 1, 1, 0, 0);
      goto_page(2'd1);
      compare("done_err_kept", {o_hex, o_page, o_busy}, {4'h1, 2'd1, 1'b0});
      goto_page(2'd2);
      compare("done_pass_kept", {o_hex, o_page, o_busy}, {4'h0, 2'd2, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
